// File: rtl/drive_cmd_arbiter.sv
// Arbitrates the drive command bus between manual and automatic modes, with dead time on handover.
// Optional obstacle masking and block_evt reporting are built only when ARB_SAFETY_EN is defined.
module drive_cmd_arbiter #(
    parameter int unsigned DEAD_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_now,
    input  logic       man_req,
    input  logic [3:0] man_cmd,
    input  logic       auto_req,
    input  logic [3:0] auto_cmd,
    input  logic       front_detector,
    input  logic       back_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    output logic [3:0] dev_cmd,
    output logic [1:0] grant,
    output logic       busy,
    output logic       block_evt
);

    typedef enum logic [1:0] {IDLE, MAN, AUTO, DEAD} state_t;

    localparam logic [19:0] DEAD_LOAD = 20'(DEAD_CYCLES);

    state_t      state, state_nxt;
    logic        tgt_man, tgt_man_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic [3:0]  src, resolved, det_mask, cmd_nxt;
    logic [1:0]  grant_nxt;
    logic        keep, blk_nxt;

    assign det_mask = {left_detector, right_detector, back_detector, front_detector};

    // Opposing bit pairs cancel: {fwd, back} and {right, left}.
    function automatic logic [3:0] resolve_conflict(input logic [3:0] c);
        logic [3:0] r;
        r = c;
        if (c[0] && c[1]) r[1:0] = 2'b00;
        if (c[2] && c[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        tgt_man_nxt = tgt_man;
        cnt_nxt     = cnt;
        if (!power_now) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (man_req)       state_nxt = MAN;
                    else if (auto_req) state_nxt = AUTO;
                end
                MAN: begin
                    if (!man_req) begin
                        if (auto_req) begin
                            state_nxt   = DEAD;
                            tgt_man_nxt = 1'b0;
                            cnt_nxt     = DEAD_LOAD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                AUTO: begin
                    if (man_req) begin
                        state_nxt   = DEAD;
                        tgt_man_nxt = 1'b1;
                        cnt_nxt     = DEAD_LOAD;
                    end else if (!auto_req) begin
                        state_nxt = IDLE;
                    end
                end
                DEAD: begin
                    cnt_nxt = (cnt == 20'd0) ? 20'd0 : cnt - 20'd1;
                    if (!tgt_man && man_req) tgt_man_nxt = 1'b1;
                    // Leave on the cycle the count reaches zero, so busy lasts exactly DEAD_CYCLES.
                    if (cnt <= 20'd1) begin
                        if (tgt_man_nxt ? man_req : auto_req)
                            state_nxt = tgt_man_nxt ? MAN : AUTO;
                        else if (tgt_man_nxt ? auto_req : man_req)
                            state_nxt = tgt_man_nxt ? AUTO : MAN;
                        else
                            state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        src       = 4'b0000;
        grant_nxt = 2'b00;
        unique case (state)
            MAN:     src = man_cmd;
            AUTO:    src = auto_cmd;
            default: src = 4'b0000;
        endcase
        unique case (state_nxt)
            MAN:     grant_nxt = 2'b01;
            AUTO:    grant_nxt = 2'b10;
            default: grant_nxt = 2'b00;
        endcase
        // Commands pass only while the current owner also keeps ownership next cycle.
        keep     = (state == MAN || state == AUTO) && (state_nxt == state);
        resolved = resolve_conflict(src);
`ifdef ARB_SAFETY_EN
        cmd_nxt = keep ? (resolved & ~det_mask) : 4'b0000;
        blk_nxt = keep && |(resolved & det_mask);
`else
        cmd_nxt = keep ? resolved : 4'b0000;
        blk_nxt = 1'b0;
`endif
    end

`ifndef ARB_SAFETY_EN
    logic unused_det;
    assign unused_det = ^det_mask;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tgt_man   <= 1'b1;
            cnt       <= 20'd0;
            dev_cmd   <= 4'b0000;
            grant     <= 2'b00;
            busy      <= 1'b0;
            block_evt <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt_man   <= tgt_man_nxt;
            cnt       <= cnt_nxt;
            dev_cmd   <= cmd_nxt;
            grant     <= grant_nxt;
            busy      <= (state_nxt == DEAD);
            block_evt <= blk_nxt;
        end
    end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter: directed scenarios then random traffic against an owner-level model.
// Expectations follow ARB_SAFETY_EN the same way the design does.
module tb_drive_cmd_arbiter;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst, power_now, man_req, auto_req;
    logic [3:0] man_cmd, auto_cmd;
    logic       front_detector, back_detector, left_detector, right_detector;
    logic [3:0] dev_cmd;
    logic [1:0] grant;
    logic       busy, block_evt;

    int checks   = 0;
    int failures = 0;

    // Model: owner 0 none / 1 manual / 2 auto; during handover owner is 0 and dead is set.
    int         m_owner = 0, m_tgt = 1, m_left = 0;
    bit         m_dead  = 1'b0;
    logic [3:0] e_cmd   = 4'b0;
    logic [1:0] e_grant = 2'b0;
    logic       e_busy  = 1'b0, e_blk = 1'b0;

    drive_cmd_arbiter #(.DEAD_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .power_now(power_now),
        .man_req(man_req), .man_cmd(man_cmd),
        .auto_req(auto_req), .auto_cmd(auto_cmd),
        .front_detector(front_detector), .back_detector(back_detector),
        .left_detector(left_detector), .right_detector(right_detector),
        .dev_cmd(dev_cmd), .grant(grant), .busy(busy), .block_evt(block_evt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic bit req_of(input int o);
        return (o == 1) ? man_req : auto_req;
    endfunction

    task automatic model_step();
        int         prev;
        logic [3:0] c, det, f;
        prev = m_owner;
        if (rst) begin
            m_owner = 0; m_dead = 1'b0; m_tgt = 1; m_left = 0;
            e_cmd = 4'b0; e_grant = 2'b0; e_busy = 1'b0; e_blk = 1'b0;
        end else begin
            if (!power_now) begin
                m_owner = 0; m_dead = 1'b0;
            end else if (m_dead) begin
                if (m_tgt == 2 && man_req) m_tgt = 1;
                m_left--;
                if (m_left == 0) begin
                    m_dead = 1'b0;
                    if (req_of(m_tgt))          m_owner = m_tgt;
                    else if (req_of(3 - m_tgt)) m_owner = 3 - m_tgt;
                    else                        m_owner = 0;
                end
            end else begin
                case (m_owner)
                    0: m_owner = man_req ? 1 : (auto_req ? 2 : 0);
                    1: if (!man_req) begin
                           m_owner = 0;
                           if (auto_req) begin m_dead = 1'b1; m_tgt = 2; m_left = DC; end
                       end
                    default: if (man_req) begin
                           m_owner = 0; m_dead = 1'b1; m_tgt = 1; m_left = DC;
                       end else if (!auto_req) m_owner = 0;
                endcase
            end
            e_grant = 2'(m_owner);
            e_busy  = m_dead;
            e_cmd   = 4'b0;
            e_blk   = 1'b0;
            if (prev != 0 && m_owner == prev) begin
                c = (prev == 1) ? man_cmd : auto_cmd;
                f[0] = c[0] & ~c[1];
                f[1] = c[1] & ~c[0];
                f[2] = c[2] & ~c[3];
                f[3] = c[3] & ~c[2];
                det = {left_detector, right_detector, back_detector, front_detector};
`ifdef ARB_SAFETY_EN
                e_cmd = f & ~det;
                e_blk = |(f & det);
`else
                e_cmd = f;
`endif
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_dev_cmd", dev_cmd, e_cmd);
        check("model_grant", {2'b0, grant}, {2'b0, e_grant});
        check("model_busy", {3'b0, busy}, {3'b0, e_busy});
        check("model_block_evt", {3'b0, block_evt}, {3'b0, e_blk});
    endtask

    task automatic set_det(input logic f, input logic b, input logic l, input logic r);
        front_detector = f; back_detector = b; left_detector = l; right_detector = r;
    endtask

    initial begin
        rst = 1'b1; power_now = 1'b0; man_req = 1'b0; auto_req = 1'b0;
        man_cmd = 4'b0; auto_cmd = 4'b0;
        set_det(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset for two cycles, then manual takes ownership from IDLE.
        cycle(); cycle();
        check("reset_dev_cmd", dev_cmd, 4'b0000);
        check("reset_grant", {2'b0, grant}, 4'b0000);
        check("reset_busy", {3'b0, busy}, 4'b0000);
        rst = 1'b0; power_now = 1'b1; man_req = 1'b1; man_cmd = 4'b0001;
        cycle();
        check("man_grant", {2'b0, grant}, 4'b0001);
        check("man_cmd_latency", dev_cmd, 4'b0000);
        cycle();
        check("man_dev_cmd", dev_cmd, 4'b0001);

        // Manual releases while auto requests: four dead cycles, then auto.
        man_req = 1'b0; auto_req = 1'b1; auto_cmd = 4'b1000;
        for (int i = 0; i < DC; i++) begin
            cycle();
            check("dead_busy", {3'b0, busy}, 4'b0001);
            check("dead_dev_cmd", dev_cmd, 4'b0000);
        end
        cycle();
        check("auto_grant", {2'b0, grant}, 4'b0010);
        check("auto_busy_low", {3'b0, busy}, 4'b0000);
        cycle();
        check("auto_dev_cmd", dev_cmd, 4'b1000);

        // Manual preempts auto.
        man_req = 1'b1; man_cmd = 4'b0001;
        for (int i = 0; i < DC; i++) begin
            cycle();
            check("preempt_no_auto_busy", {3'b0, busy && grant == 2'b10}, 4'b0000);
        end
        cycle();
        check("preempt_grant", {2'b0, grant}, 4'b0001);
        cycle();
        check("preempt_dev_cmd", dev_cmd, 4'b0001);

        // Front obstacle suppresses forward.
        set_det(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
`ifdef ARB_SAFETY_EN
            check("safety_dev_cmd", dev_cmd, 4'b0000);
            check("safety_block_evt", {3'b0, block_evt}, 4'b0001);
`else
            check("nosafety_dev_cmd", dev_cmd, 4'b0001);
            check("nosafety_block_evt", {3'b0, block_evt}, 4'b0000);
`endif
        end

        // Opposing bits cancel without reporting a block.
        set_det(1'b0, 1'b0, 1'b0, 1'b0);
        man_cmd = 4'b1100;
        cycle();
        check("conflict_lr_cmd", dev_cmd, 4'b0000);
        check("conflict_lr_blk", {3'b0, block_evt}, 4'b0000);
        man_cmd = 4'b0011;
        cycle();
        check("conflict_fb_cmd", dev_cmd, 4'b0000);
        check("conflict_fb_blk", {3'b0, block_evt}, 4'b0000);

        // Power drops mid handover at counter 2.
        man_req = 1'b0; auto_req = 1'b1;
        cycle(); cycle(); cycle();
        power_now = 1'b0;
        cycle();
        check("poweroff_busy", {3'b0, busy}, 4'b0000);
        check("poweroff_grant", {2'b0, grant}, 4'b0000);
        check("poweroff_dev_cmd", dev_cmd, 4'b0000);
        power_now = 1'b1;
        cycle(); cycle();

        // Reset mid handover aborts; manual then wins straight from IDLE.
        man_req = 1'b1;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        check("rst_dead_busy", {3'b0, busy}, 4'b0000);
        check("rst_dead_grant", {2'b0, grant}, 4'b0000);
        rst = 1'b0;
        cycle();
        check("rst_release_grant", {2'b0, grant}, 4'b0001);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 11) == 0) man_req = ~man_req;
            if ($urandom_range(0, 11) == 0) auto_req = ~auto_req;
            power_now = ($urandom_range(0, 149) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            man_cmd   = 4'($urandom);
            auto_cmd  = 4'($urandom);
            set_det($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
